puf_key_vote_launcher: RTL and testbench
========================================

// Module: puf_key_vote_launcher
// PURPOSE
//  Sits between keygenerator and AES_circuit. Temporal majority-vote over NVOTE PUF key
//  readouts yields a stable 128-bit key and counts noisy bits. Sequences one AES run per
//  start request: latches plaintext, drives the AES reset and waits for done with a timeout.
//  Captures the ciphertext. Replaces the level-sensitive enable/data latch at top level.
// PARAMETERS
//  NVOTE    7   PUF readouts per key; odd, 3..15
//  TIMEOUT  64  max RUN cycles waiting for aes_done before error; 2..255
// PORTS
//  clk            in   1    system clock, all logic on rising edge
//  reset          in   1    asynchronous, active-low; clears all state
//  key_in         in   128  raw PUF key from keygenerator key_out
//  key_valid      in   1    keygenerator enable; each high cycle in COLLECT = one vote
//  rekey          in   1    1-cycle pulse: discard voted key, re-collect
//  start          in   1    1-cycle pulse: encrypt data_in with voted key
//  data_in        in   128  plaintext
//  cipher_in      in   128  AES_circuit data_out
//  aes_done       in   1    AES_circuit sure
//  aes_key        out  128  voted key to AES_circuit; 0 until key_ready
//  aes_data       out  128  latched plaintext to AES_circuit
//  aes_rst        out  1    active-high AES reset; high except in RUN
//  cipher_out     out  128  captured ciphertext
//  cipher_valid   out  1    high from DONE until next accepted start/rekey
//  key_ready      out  1    voted key valid
//  busy           out  1    high in COLLECT, LAUNCH, RUN
//  timeout_err    out  1    sticky until next accepted start/rekey
//  unstable_bits  out  8    key bits whose NVOTE readouts were not unanimous (0..128)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except aes_rst=1; vote and timeout counters 0.
//  FSM: IDLE, COLLECT, KEYED, LAUNCH, RUN, DONE, ERR.
//  - IDLE: clear per-bit ones counters and vote_cnt. key_valid=1 -> COLLECT (no vote taken this cycle).
//  - COLLECT: each cycle key_valid=1: ones[i]+=key_in[i], vote_cnt++. key_valid=0 pauses
//    without losing votes. vote_cnt==NVOTE -> KEYED. On that transition register
//    aes_key[i]=(ones[i]>NVOTE/2) and unstable_bits=#bits with 0<ones[i]<NVOTE.
//    key_ready=1 one cycle after the final vote.
//  - KEYED: start -> LAUNCH; rekey -> IDLE (key_ready=0, aes_key=0, unstable_bits=0).
//    If start and rekey are high in the same cycle, rekey wins.
//  - LAUNCH (1 cycle): aes_data<=data_in, aes_rst=1, clear cipher_valid/timeout_err/tmo_cnt -> RUN.
//  - RUN: aes_rst=0; tmo_cnt++ each cycle. aes_done=1 -> DONE. Else if tmo_cnt reaches
//    TIMEOUT-1 -> ERR. If aes_done arrives in the expiry cycle, done wins.
//  - DONE (1 cycle): cipher_out<=cipher_in, cipher_valid=1, aes_rst=1 -> KEYED.
//  - ERR: timeout_err=1, aes_rst=1; start -> LAUNCH (retry), rekey -> IDLE.
//  start is ignored outside KEYED/ERR; rekey is ignored in COLLECT/LAUNCH/RUN.
//  Latency: start at cycle t -> aes_data loaded and aes_rst=1 at t+1 -> aes_rst=0 from t+2.
//  aes_done at cycle u -> cipher_out/cipher_valid visible at u+1.
//  Ones counters are 4 bits and cannot wrap because NVOTE<=15. cipher_out holds its value
//  across a rekey; cipher_valid drops.
//  Reset mid-operation (any state) -> IDLE immediately; the key is erased.
// TESTING
//  1 NVOTE=7, key_in=2b7e151628aed2a6abf7158809cf4f3c for 7 cycles -> aes_key equals it, unstable_bits=0, key_ready after 8th cycle.
//  2 4 votes of K, 3 votes of K^128'h1 with key_valid gaps -> aes_key=K, unstable_bits=1; 4 votes K^1 -> bit0 set.
//  3 Keyed with K from test 1; start, data_in=3243f6a8885a308d313198a2e0370734 with real AES_circuit -> cipher_out=3925841d02dc09fbdc118597196a0b32; check LAUNCH/RUN timing.
//  4 aes_done held 0 -> timeout_err=1 exactly TIMEOUT cycles after RUN entry, aes_rst=1; start retries; done in the expiry cycle -> DONE, no err.
//  5 start+rekey same cycle in KEYED -> IDLE, key_ready=0, aes_key=0; start during RUN ignored.
//  6 reset low mid-RUN and mid-COLLECT -> all outputs at reset values same cycle, new collection needs full NVOTE votes.

Source files
------------

// File: rtl/puf_key_vote_launcher.sv
// PUF key majority voter and one-shot AES run sequencer between keygenerator and AES_circuit.
// Each key bit owns a small ones counter; the top FSM collects votes, then launches and times AES runs.

module puf_vote_bit #(
    parameter int NVOTE = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic vote,
    input  logic bit_in,
    output logic maj,
    output logic noisy
);
    localparam logic [3:0] HALF = 4'(NVOTE / 2);
    localparam logic [3:0] NV   = 4'(NVOTE);

    logic [3:0] ones, ones_nxt;

    // Verdict is taken from the post-vote count so the final vote is included.
    assign ones_nxt = ones + {3'b000, bit_in};
    assign maj      = ones_nxt > HALF;
    assign noisy    = (ones_nxt != 4'd0) && (ones_nxt != NV);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    ones <= 4'd0;
        else if (clr)  ones <= 4'd0;
        else if (vote) ones <= ones_nxt;
    end
endmodule

module puf_key_vote_launcher #(
    parameter int NVOTE   = 7,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    input  logic         rekey,
    input  logic         start,
    input  logic [127:0] data_in,
    input  logic [127:0] cipher_in,
    input  logic         aes_done,
    output logic [127:0] aes_key,
    output logic [127:0] aes_data,
    output logic         aes_rst,
    output logic [127:0] cipher_out,
    output logic         cipher_valid,
    output logic         key_ready,
    output logic         busy,
    output logic         timeout_err,
    output logic [7:0]   unstable_bits
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] COLLECT = 3'd1;
    localparam logic [2:0] KEYED   = 3'd2;
    localparam logic [2:0] LAUNCH  = 3'd3;
    localparam logic [2:0] RUN     = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;
    localparam logic [2:0] ERR     = 3'd6;

    localparam logic [3:0] VOTE_LAST = 4'(NVOTE - 1);
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    logic [2:0]   state, state_nxt;
    logic [3:0]   vote_cnt;
    logic [7:0]   tmo_cnt;
    logic [127:0] maj, noisy;
    logic [7:0]   ucnt;
    logic         clr, vote, final_vote, acc_start, acc_rekey, expire;

    assign clr        = (state == IDLE);
    assign vote       = (state == COLLECT) && key_valid;
    assign final_vote = vote && (vote_cnt == VOTE_LAST);
    assign acc_rekey  = rekey && (state == KEYED || state == ERR || state == DONE);
    assign acc_start  = start && !rekey && (state == KEYED || state == ERR);
    assign expire     = (state == RUN) && !aes_done && (tmo_cnt == TMO_LAST);
    assign aes_rst    = (state != RUN);
    assign busy       = (state == COLLECT) || (state == LAUNCH) || (state == RUN);

    for (genvar gi = 0; gi < 128; gi++) begin : g_bit
        puf_vote_bit #(.NVOTE(NVOTE)) u_bit (
            .clk    (clk),
            .reset  (reset),
            .clr    (clr),
            .vote   (vote),
            .bit_in (key_in[gi]),
            .maj    (maj[gi]),
            .noisy  (noisy[gi])
        );
    end

    always_comb begin
        ucnt = 8'd0;
        for (int i = 0; i < 128; i++) ucnt = ucnt + 8'(noisy[i]);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (key_valid) state_nxt = COLLECT;
            COLLECT: if (final_vote) state_nxt = KEYED;
            KEYED,
            ERR:     if (rekey) state_nxt = IDLE;
                     else if (start) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = RUN;
            RUN:     if (aes_done) state_nxt = DONE;
                     else if (expire) state_nxt = ERR;
            DONE:    state_nxt = rekey ? IDLE : KEYED;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            vote_cnt      <= 4'd0;
            tmo_cnt       <= 8'd0;
            aes_key       <= '0;
            aes_data      <= '0;
            cipher_out    <= '0;
            cipher_valid  <= 1'b0;
            key_ready     <= 1'b0;
            timeout_err   <= 1'b0;
            unstable_bits <= 8'd0;
        end else begin
            state <= state_nxt;
            if (clr)       vote_cnt <= 4'd0;
            else if (vote) vote_cnt <= vote_cnt + 4'd1;

            if (acc_rekey) begin
                aes_key       <= '0;
                key_ready     <= 1'b0;
                unstable_bits <= 8'd0;
                cipher_valid  <= 1'b0;
                timeout_err   <= 1'b0;
            end else if (final_vote) begin
                aes_key       <= maj;
                key_ready     <= 1'b1;
                unstable_bits <= ucnt;
            end

            // Plaintext and status are refreshed on the accepting edge so LAUNCH already sees them.
            if (acc_start) begin
                aes_data     <= data_in;
                cipher_valid <= 1'b0;
                timeout_err  <= 1'b0;
                tmo_cnt      <= 8'd0;
            end

            if (state == RUN) begin
                tmo_cnt <= tmo_cnt + 8'd1;
                if (aes_done) begin
                    cipher_out   <= cipher_in;
                    cipher_valid <= 1'b1;
                end else if (expire) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_puf_key_vote_launcher.sv
// Directed bench for puf_key_vote_launcher: voting, AES launch timing, timeout, priority, reset.
`timescale 1ns/1ps

module tb_puf_key_vote_launcher;
    localparam int NVOTE   = 7;
    localparam int TIMEOUT = 64;
    localparam logic [127:0] K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3d;
    localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT2 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] PT2 = 128'h00112233445566778899aabbccddeeff;

    logic         clk, reset;
    logic [127:0] key_in, data_in, cipher_in;
    logic         key_valid, rekey, start, aes_done;
    logic [127:0] aes_key, aes_data, cipher_out;
    logic         aes_rst, cipher_valid, key_ready, busy, timeout_err;
    logic [7:0]   unstable_bits;

    int checks = 0;
    int errors = 0;

    puf_key_vote_launcher #(.NVOTE(NVOTE), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .key_in        (key_in),
        .key_valid     (key_valid),
        .rekey         (rekey),
        .start         (start),
        .data_in       (data_in),
        .cipher_in     (cipher_in),
        .aes_done      (aes_done),
        .aes_key       (aes_key),
        .aes_data      (aes_data),
        .aes_rst       (aes_rst),
        .cipher_out    (cipher_out),
        .cipher_valid  (cipher_valid),
        .key_ready     (key_ready),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .unstable_bits (unstable_bits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vote(input logic [127:0] k);
        key_in = k; key_valid = 1'b1; tick(); key_valid = 1'b0;
    endtask

    task automatic collect(input logic [127:0] k);
        key_valid = 1'b1; tick();
        repeat (NVOTE) vote(k);
    endtask

    task automatic pulse_rekey();
        rekey = 1'b1; tick(); rekey = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; key_in = '0; key_valid = 0; rekey = 0; start = 0;
        data_in = '0; cipher_in = '0; aes_done = 0;
        #12;
        checks++; if (aes_rst !== 1'b1) begin errors++; $display("FAIL reset_aes_rst: got %b want 1", aes_rst); end
        checks++; if ({key_ready, busy, cipher_valid, timeout_err} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {key_ready, busy, cipher_valid, timeout_err}); end
        checks++; if ((aes_key | aes_data | cipher_out) !== '0 || unstable_bits !== 8'd0) begin errors++; $display("FAIL reset_data: key %h data %h ct %h ub %0d want 0", aes_key, aes_data, cipher_out, unstable_bits); end
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_unanimous();
        key_in = K; key_valid = 1'b1; tick();
        checks++; if (busy !== 1'b1 || key_ready !== 1'b0) begin errors++; $display("FAIL collect_enter: busy %b ready %b want 1 0", busy, key_ready); end
        repeat (NVOTE - 1) tick();
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL ready_early: got %b want 0 after 7 cycles", key_ready); end
        tick();
        key_valid = 1'b0;
        checks++; if (key_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ready_8th: ready %b busy %b want 1 0", key_ready, busy); end
        checks++; if (aes_key !== K) begin errors++; $display("FAIL key_unanimous: got %h want %h", aes_key, K); end
        checks++; if (unstable_bits !== 8'd0) begin errors++; $display("FAIL unstable_zero: got %0d want 0", unstable_bits); end
    endtask

    task automatic test_noisy();
        pulse_rekey();
        checks++; if (key_ready !== 1'b0 || aes_key !== '0) begin errors++; $display("FAIL rekey_clear: ready %b key %h want 0", key_ready, aes_key); end
        key_valid = 1'b1; tick();
        vote(K); tick(); vote(K); vote(K); tick(); tick(); vote(K);
        vote(K1); tick(); vote(K1);
        checks++; if (key_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL gap_pause: ready %b busy %b want 0 1", key_ready, busy); end
        vote(K1);
        checks++; if (key_ready !== 1'b1 || aes_key !== K) begin errors++; $display("FAIL maj_k: ready %b key %h want 1 %h", key_ready, aes_key, K); end
        checks++; if (unstable_bits !== 8'd1) begin errors++; $display("FAIL unstable_one: got %0d want 1", unstable_bits); end
        pulse_rekey();
        key_valid = 1'b1; tick();
        vote(K1); vote(K); tick(); vote(K1); vote(K); vote(K1); tick(); vote(K); vote(K1);
        checks++; if (aes_key !== K1 || unstable_bits !== 8'd1) begin errors++; $display("FAIL maj_k1: key %h ub %0d want %h 1", aes_key, unstable_bits, K1); end
    endtask

    task automatic test_aes_run();
        pulse_rekey();
        collect(K);
        data_in = PT; start = 1'b1; tick(); start = 1'b0; data_in = '0;
        checks++; if (aes_data !== PT || aes_rst !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL launch: data %h rst %b busy %b want %h 1 1", aes_data, aes_rst, busy, PT); end
        tick();
        checks++; if (aes_rst !== 1'b0) begin errors++; $display("FAIL run_rst: got %b want 0", aes_rst); end
        repeat (9) tick();
        cipher_in = (aes_key === K && aes_data === PT) ? CT : '0;
        aes_done = 1'b1; tick(); aes_done = 1'b0;
        checks++; if (cipher_out !== CT || cipher_valid !== 1'b1) begin errors++; $display("FAIL cipher: got %h v%b want %h v1", cipher_out, cipher_valid, CT); end
        checks++; if (aes_rst !== 1'b1 || busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL done_state: rst %b busy %b err %b want 1 0 0", aes_rst, busy, timeout_err); end
        tick();
        checks++; if (cipher_valid !== 1'b1 || key_ready !== 1'b1) begin errors++; $display("FAIL keyed_hold: v %b ready %b want 1 1", cipher_valid, key_ready); end
    endtask

    task automatic test_timeout();
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (cipher_valid !== 1'b0) begin errors++; $display("FAIL launch_clr_valid: got %b want 0", cipher_valid); end
        tick();
        repeat (TIMEOUT - 1) tick();
        checks++; if (timeout_err !== 1'b0 || aes_rst !== 1'b0) begin errors++; $display("FAIL tmo_early: err %b rst %b want 0 0", timeout_err, aes_rst); end
        tick();
        checks++; if (timeout_err !== 1'b1 || aes_rst !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tmo_err: err %b rst %b busy %b want 1 1 0", timeout_err, aes_rst, busy); end
        tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b want 1", timeout_err); end
        start = 1'b1; tick(); start = 1'b0;
        checks++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL retry_launch: err %b busy %b want 0 1", timeout_err, busy); end
        tick();
        repeat (TIMEOUT - 1) tick();
        cipher_in = CT2; aes_done = 1'b1; tick(); aes_done = 1'b0;
        checks++; if (cipher_valid !== 1'b1 || timeout_err !== 1'b0 || cipher_out !== CT2) begin errors++; $display("FAIL done_wins: v %b err %b ct %h want 1 0 %h", cipher_valid, timeout_err, cipher_out, CT2); end
        tick();
    endtask

    task automatic test_priority();
        start = 1'b1; rekey = 1'b1; tick(); start = 1'b0; rekey = 1'b0;
        checks++; if (key_ready !== 1'b0 || aes_key !== '0 || busy !== 1'b0 || aes_rst !== 1'b1) begin errors++; $display("FAIL rekey_wins: ready %b key %h busy %b rst %b want 0 0 0 1", key_ready, aes_key, busy, aes_rst); end
        checks++; if (cipher_valid !== 1'b0 || cipher_out !== CT2) begin errors++; $display("FAIL ct_hold: v %b ct %h want 0 %h", cipher_valid, cipher_out, CT2); end
        collect(K);
        data_in = PT; start = 1'b1; tick(); start = 1'b0;
        tick();
        data_in = PT2; start = 1'b1; tick(); start = 1'b0;
        checks++; if (aes_rst !== 1'b0 || busy !== 1'b1 || aes_data !== PT) begin errors++; $display("FAIL start_in_run: rst %b busy %b data %h want 0 1 %h", aes_rst, busy, aes_data, PT); end
        cipher_in = CT; aes_done = 1'b1; tick(); aes_done = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        data_in = PT2; start = 1'b1; tick(); start = 1'b0;
        tick();
        #2 reset = 1'b0; #1;
        checks++; if (aes_rst !== 1'b1 || {key_ready, busy, cipher_valid, timeout_err} !== 4'b0) begin errors++; $display("FAIL rst_run_flags: rst %b flags %b want 1 0000", aes_rst, {key_ready, busy, cipher_valid, timeout_err}); end
        checks++; if ((aes_key | aes_data | cipher_out) !== '0 || unstable_bits !== 8'd0) begin errors++; $display("FAIL rst_run_data: key %h data %h ct %h want 0", aes_key, aes_data, cipher_out); end
        #2 reset = 1'b1;
        tick();
        key_valid = 1'b1; tick();
        repeat (3) vote(~K);
        #2 reset = 1'b0; #1;
        checks++; if (busy !== 1'b0 || key_ready !== 1'b0) begin errors++; $display("FAIL rst_collect: busy %b ready %b want 0 0", busy, key_ready); end
        #2 reset = 1'b1;
        tick();
        key_valid = 1'b1; tick();
        repeat (NVOTE - 1) vote(~K);
        checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL full_votes: ready %b want 0 after 6 votes", key_ready); end
        vote(~K);
        checks++; if (key_ready !== 1'b1 || aes_key !== ~K || unstable_bits !== 8'd0) begin errors++; $display("FAIL recollect: ready %b key %h ub %0d want 1 %h 0", key_ready, aes_key, unstable_bits, ~K); end
    endtask

    initial begin
        test_reset();
        test_unanimous();
        test_noisy();
        test_aes_run();
        test_timeout();
        test_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
